// File: rtl/sdram_traffic_gen_if.sv
// Burst handshake bundle between the SDRAM traffic generator (master) and an
// SDRAM controller's application port (slave).
interface sdram_traffic_gen_if #(
    parameter int SDR_DQ_WIDTH    = 16,
    parameter int APP_ADDR_WIDTH  = 24,
    parameter int APP_BURST_WIDTH = 10
);
    logic                       wr_burst_req;
    logic [APP_BURST_WIDTH-1:0] wr_burst_len;
    logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr;
    logic [SDR_DQ_WIDTH-1:0]    wr_burst_data;
    logic                       wr_burst_data_req;
    logic                       wr_burst_finish;
    logic                       rd_burst_req;
    logic [APP_BURST_WIDTH-1:0] rd_burst_len;
    logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr;
    logic [SDR_DQ_WIDTH-1:0]    rd_burst_data;
    logic                       rd_burst_data_valid;
    logic                       rd_burst_finish;

    modport master (
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  wr_burst_data_req, wr_burst_finish,
        input  rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output wr_burst_data_req, wr_burst_finish,
        output rd_burst_data, rd_burst_data_valid, rd_burst_finish
    );
endinterface

// File: rtl/sdram_traffic_gen.sv
// SDRAM traffic generator: writes NUM_BURSTS bursts of a known pattern, reads
// them back, compares every returned word and reports errors/timeout.
module sdram_traffic_gen #(
    parameter int SDR_DQ_WIDTH    = 16,
    parameter int APP_ADDR_WIDTH  = 24,
    parameter int APP_BURST_WIDTH = 10,
    parameter int BURST_LEN       = 8,
    parameter int NUM_BURSTS      = 16,
    parameter int START_ADDR      = 0,
    parameter int PATTERN         = 0,
    parameter int TIMEOUT         = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    sdram_traffic_gen_if.master       bus,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [15:0]               err_count,
    output logic [APP_ADDR_WIDTH-1:0] first_err_addr
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [15:0]                LFSR_SEED  = 16'hFFFF;
    localparam logic [SDR_DQ_WIDTH-1:0]    ONE_W      = {{(SDR_DQ_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SDR_DQ_WIDTH-1:0]    ZERO_W     = {SDR_DQ_WIDTH{1'b0}};
    localparam logic [APP_ADDR_WIDTH-1:0]  BASE_ADDR  = APP_ADDR_WIDTH'(START_ADDR);
    localparam logic [APP_ADDR_WIDTH-1:0]  ADDR_STEP  = APP_ADDR_WIDTH'(BURST_LEN);
    localparam logic [APP_ADDR_WIDTH-1:0]  ADDR_ZERO  = {APP_ADDR_WIDTH{1'b0}};
    localparam logic [APP_BURST_WIDTH-1:0] LEN_W      = APP_BURST_WIDTH'(BURST_LEN);
    localparam logic [APP_BURST_WIDTH-1:0] LEN_ZERO   = {APP_BURST_WIDTH{1'b0}};
    localparam logic [31:0]                LAST_BURST = 32'(NUM_BURSTS - 1);
    localparam logic [31:0]                WD_LAST    = 32'(TIMEOUT - 1);
    localparam logic [31:0]                K_STEP     = 32'(BURST_LEN);
    localparam logic [1:0]                 MODE       = 2'(PATTERN);

    // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Advances the LFSR by one whole burst; unrolls into a fixed XOR network
    function automatic logic [15:0] lfsr_jump(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < BURST_LEN; i++) begin
            t = lfsr_next(t);
        end
        return t;
    endfunction

    function automatic logic [SDR_DQ_WIDTH-1:0] pattern_word(input logic [31:0] k,
                                                             input logic [15:0] lfsr);
        logic [SDR_DQ_WIDTH-1:0] w;
        w = ZERO_W;
        case (MODE)
            2'd0: w = SDR_DQ_WIDTH'(k);
            2'd1: begin
                for (int i = 0; i < SDR_DQ_WIDTH; i++) begin
                    w[i] = lfsr[i[3:0]];
                end
            end
            2'd2:    w = ONE_W << (k % 32'(SDR_DQ_WIDTH));
            default: w = ZERO_W;
        endcase
        return w;
    endfunction

    state_t                      state_r, state_nx_s;
    logic                        wr_req_r, rd_req_r, wr_req_s, rd_req_s, busy_s;
    logic [APP_ADDR_WIDTH-1:0]   wr_addr_r, rd_addr_r, burst_addr_r, first_err_r;
    logic [APP_BURST_WIDTH-1:0]  wr_len_r, rd_len_r;
    logic [31:0]                 burst_idx_r, k_r, k_base_r, wd_r;
    logic [15:0]                 lfsr_r, lfsr_base_r, err_count_r;
    logic                        busy_r, done_r, pass_r, timeout_r;
    logic [SDR_DQ_WIDTH-1:0]     exp_word_s;
    logic                        last_burst_s, wd_hit_s, err_s;

    assign exp_word_s   = pattern_word(k_r, lfsr_r);
    assign last_burst_s = (burst_idx_r == LAST_BURST);
    assign wd_hit_s     = (wd_r == WD_LAST);
    assign err_s        = (state_r == ST_RD_WAIT) && bus.rd_burst_data_valid &&
                          (bus.rd_burst_data != exp_word_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; finish outranks the watchdog when both land together
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx_s = ST_WR_REQ;
                else       state_nx_s = state_r;
            end
            ST_WR_REQ: state_nx_s = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (bus.wr_burst_finish) state_nx_s = last_burst_s ? ST_RD_REQ : ST_WR_REQ;
                else if (wd_hit_s)       state_nx_s = ST_DONE;
                else                     state_nx_s = ST_WR_WAIT;
            end
            ST_RD_REQ: state_nx_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (bus.rd_burst_finish) state_nx_s = last_burst_s ? ST_DONE : ST_RD_REQ;
                else if (wd_hit_s)       state_nx_s = ST_DONE;
                else                     state_nx_s = ST_RD_WAIT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered request strobes and busy
    always_comb begin
        wr_req_s = 1'b0;
        rd_req_s = 1'b0;
        case (state_r)
            ST_WR_REQ:  wr_req_s = 1'b1;
            ST_WR_WAIT: wr_req_s = !bus.wr_burst_finish && !wd_hit_s;
            ST_RD_REQ:  rd_req_s = 1'b1;
            ST_RD_WAIT: rd_req_s = !bus.rd_burst_finish && !wd_hit_s;
            default: begin
                wr_req_s = 1'b0;
                rd_req_s = 1'b0;
            end
        endcase
        busy_s = (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
    end

    // Datapath: burst addressing, pattern generator, checker, status
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_req_r     <= 1'b0;
            rd_req_r     <= 1'b0;
            wr_addr_r    <= ADDR_ZERO;
            rd_addr_r    <= ADDR_ZERO;
            wr_len_r     <= LEN_ZERO;
            rd_len_r     <= LEN_ZERO;
            burst_addr_r <= ADDR_ZERO;
            burst_idx_r  <= 32'd0;
            k_r          <= 32'd0;
            k_base_r     <= 32'd0;
            wd_r         <= 32'd0;
            lfsr_r       <= LFSR_SEED;
            lfsr_base_r  <= LFSR_SEED;
            err_count_r  <= 16'd0;
            first_err_r  <= ADDR_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            wr_req_r <= wr_req_s;
            rd_req_r <= rd_req_s;
            busy_r   <= busy_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        timeout_r    <= 1'b0;
                        err_count_r  <= 16'd0;
                        first_err_r  <= ADDR_ZERO;
                        burst_idx_r  <= 32'd0;
                        burst_addr_r <= BASE_ADDR;
                        k_r          <= 32'd0;
                        k_base_r     <= 32'd0;
                        lfsr_r       <= LFSR_SEED;
                        lfsr_base_r  <= LFSR_SEED;
                    end
                end
                ST_WR_REQ: begin
                    wr_addr_r <= burst_addr_r;
                    wr_len_r  <= LEN_W;
                    wd_r      <= 32'd0;
                end
                ST_WR_WAIT: begin
                    wd_r <= wd_r + 32'd1;
                    if (bus.wr_burst_data_req) begin
                        k_r    <= k_r + 32'd1;
                        lfsr_r <= lfsr_next(lfsr_r);
                    end
                    // Later assignments override the data advance on the finish beat
                    if (bus.wr_burst_finish) begin
                        if (last_burst_s) begin
                            burst_idx_r  <= 32'd0;
                            burst_addr_r <= BASE_ADDR;
                            k_r          <= 32'd0;
                            k_base_r     <= 32'd0;
                            lfsr_r       <= LFSR_SEED;
                            lfsr_base_r  <= LFSR_SEED;
                        end else begin
                            burst_idx_r  <= burst_idx_r + 32'd1;
                            burst_addr_r <= burst_addr_r + ADDR_STEP;
                        end
                    end else if (wd_hit_s) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        pass_r    <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    rd_addr_r <= burst_addr_r;
                    rd_len_r  <= LEN_W;
                    wd_r      <= 32'd0;
                    k_r       <= k_base_r;
                    lfsr_r    <= lfsr_base_r;
                end
                ST_RD_WAIT: begin
                    wd_r <= wd_r + 32'd1;
                    if (bus.rd_burst_data_valid) begin
                        k_r    <= k_r + 32'd1;
                        lfsr_r <= lfsr_next(lfsr_r);
                    end
                    if (err_s) begin
                        if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
                        if (err_count_r == 16'd0)
                            first_err_r <= rd_addr_r + APP_ADDR_WIDTH'(k_r - k_base_r);
                    end
                    if (bus.rd_burst_finish) begin
                        if (last_burst_s) begin
                            done_r <= 1'b1;
                            pass_r <= (err_count_r == 16'd0) && !err_s;
                        end else begin
                            burst_idx_r  <= burst_idx_r + 32'd1;
                            burst_addr_r <= burst_addr_r + ADDR_STEP;
                            k_base_r     <= k_base_r + K_STEP;
                            lfsr_base_r  <= lfsr_jump(lfsr_base_r);
                        end
                    end else if (wd_hit_s) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        pass_r    <= 1'b0;
                    end
                end
                default: begin
                    wd_r <= 32'd0;
                end
            endcase
        end
    end

    assign bus.wr_burst_req  = wr_req_r;
    assign bus.wr_burst_len  = wr_len_r;
    assign bus.wr_burst_addr = wr_addr_r;
    assign bus.wr_burst_data = wr_req_r ? exp_word_s : ZERO_W;
    assign bus.rd_burst_req  = rd_req_r;
    assign bus.rd_burst_len  = rd_len_r;
    assign bus.rd_burst_addr = rd_addr_r;

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_r;
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Scoreboard bench for sdram_traffic_gen against an ideal burst SDRAM model
// (walking-one pattern, 4 bursts of 8 words, 64-cycle watchdog).
module tb_sdram_traffic_gen;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int BW = 10;
    localparam int BL = 8;
    localparam int NB = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] rd_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] mem [0:63];
    bit          hang_wr = 1'b0;
    int          corrupt_addr = -1;

    sdram_traffic_gen_if #(.SDR_DQ_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW)) bus ();

    sdram_traffic_gen #(
        .SDR_DQ_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW),
        .BURST_LEN(BL), .NUM_BURSTS(NB), .START_ADDR(0), .PATTERN(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_pass();
        for (int b = 0; b < NB; b++) wr_addr_q.push_back(32'(b * BL));
        for (int k = 0; k < NB * BL; k++) wr_data_q.push_back(16'h0001 << (k % 16));
        for (int b = 0; b < NB; b++) rd_addr_q.push_back(32'(b * BL));
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_queues(input string name);
        check({name, "_wr_addr_left"}, 32'(wr_addr_q.size()), 32'd0);
        check({name, "_wr_data_left"}, 32'(wr_data_q.size()), 32'd0);
        check({name, "_rd_addr_left"}, 32'(rd_addr_q.size()), 32'd0);
    endtask

    // Ideal SDRAM: one data beat per cycle, finish on the last beat
    int a_m, n_m;
    initial begin
        bus.wr_burst_data_req   = 1'b0;
        bus.wr_burst_finish     = 1'b0;
        bus.rd_burst_data       = 16'h0000;
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.wr_burst_req && !hang_wr) begin
                a_m = int'(bus.wr_burst_addr);
                n_m = int'(bus.wr_burst_len);
                for (int i = 0; i < n_m; i++) begin
                    if (rst) break;
                    bus.wr_burst_data_req = 1'b1;
                    bus.wr_burst_finish   = (i == n_m - 1);
                    #1 mem[(a_m + i) % 64] = bus.wr_burst_data;
                    @(negedge clk);
                end
                bus.wr_burst_data_req = 1'b0;
                bus.wr_burst_finish   = 1'b0;
            end else if (!rst && bus.rd_burst_req) begin
                a_m = int'(bus.rd_burst_addr);
                n_m = int'(bus.rd_burst_len);
                for (int i = 0; i < n_m; i++) begin
                    if (rst) break;
                    bus.rd_burst_data_valid = 1'b1;
                    bus.rd_burst_finish     = (i == n_m - 1);
                    bus.rd_burst_data       = mem[(a_m + i) % 64] ^
                                              (((a_m + i) == corrupt_addr) ? 16'h0001 : 16'h0000);
                    @(negedge clk);
                end
                bus.rd_burst_data_valid = 1'b0;
                bus.rd_burst_finish     = 1'b0;
            end
        end
    end

    // Monitor: pops expected burst headers and write words as the DUT presents them
    initial begin
        bit wp, rp;
        logic [31:0] e;
        wp = 1'b0;
        rp = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (bus.wr_burst_req || bus.rd_burst_req)
                check("req_exclusive", {31'd0, bus.wr_burst_req && bus.rd_burst_req}, 32'd0);
            if (bus.wr_burst_req && !wp) begin
                if (wr_addr_q.size() == 0) check("wr_burst_extra", 32'(wr_addr_q.size()), 32'd1);
                else begin
                    e = wr_addr_q.pop_front();
                    check("wr_addr", 32'(bus.wr_burst_addr), e);
                    check("wr_len", 32'(bus.wr_burst_len), 32'(BL));
                end
            end
            if (bus.wr_burst_req && bus.wr_burst_data_req) begin
                if (wr_data_q.size() == 0) check("wr_data_extra", 32'(wr_data_q.size()), 32'd1);
                else begin
                    e = 32'(wr_data_q.pop_front());
                    check("wr_data", 32'(bus.wr_burst_data), e);
                end
            end
            if (bus.rd_burst_req && !rp) begin
                if (rd_addr_q.size() == 0) check("rd_burst_extra", 32'(rd_addr_q.size()), 32'd1);
                else begin
                    e = rd_addr_q.pop_front();
                    check("rd_addr", 32'(bus.rd_burst_addr), e);
                    check("rd_len", 32'(bus.rd_burst_len), 32'(BL));
                end
            end
            wp = bus.wr_burst_req;
            rp = bus.rd_burst_req;
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_req", {31'd0, bus.wr_burst_req}, 32'd0);
        check("rst_rd_req", {31'd0, bus.rd_burst_req}, 32'd0);
        check("rst_wr_addr", 32'(bus.wr_burst_addr), 32'd0);
        check("rst_wr_len", 32'(bus.wr_burst_len), 32'd0);
        check("rst_wr_data", 32'(bus.wr_burst_data), 32'd0);
        check("rst_status", {28'd0, busy, done, pass, timeout}, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_first_err", 32'(first_err_addr), 32'd0);
        rst = 1'b0;

        // Clean pass with a stray start while busy
        push_pass();
        pulse_start();
        repeat (3) @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done("t1_done");
        check("t1_pass", {31'd0, pass}, 32'd1);
        check("t1_err_count", 32'(err_count), 32'd0);
        check("t1_timeout", {31'd0, timeout}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("t1_done_held", {30'd0, done, pass}, 32'd3);
        check_queues("t1");

        // Word 3 of burst 2 returns with bit 0 flipped
        corrupt_addr = 19;
        push_pass();
        pulse_start();
        wait_done("t2_done");
        check("t2_err_count", 32'(err_count), 32'd1);
        check("t2_first_err", 32'(first_err_addr), 32'd19);
        check("t2_pass", {31'd0, pass}, 32'd0);
        check("t2_timeout", {31'd0, timeout}, 32'd0);
        check_queues("t2");
        corrupt_addr = -1;

        // Controller never finishes the write burst
        hang_wr = 1'b1;
        wr_addr_q.push_back(32'd0);
        pulse_start();
        n = 0;
        while (!bus.wr_burst_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.wr_burst_req && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t3_req_cycles", 32'(n), 32'(TO));
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_timeout", {31'd0, timeout}, 32'd1);
        check("t3_pass", {31'd0, pass}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check_queues("t3");
        hang_wr = 1'b0;

        // Reset in the middle of the second read burst
        for (int b = 0; b < NB; b++) wr_addr_q.push_back(32'(b * BL));
        for (int k = 0; k < NB * BL; k++) wr_data_q.push_back(16'h0001 << (k % 16));
        rd_addr_q.push_back(32'd0);
        rd_addr_q.push_back(32'd8);
        pulse_start();
        n = 0;
        while (!(bus.rd_burst_req && bus.rd_burst_addr == 24'd8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_rd_burst1_seen", {31'd0, bus.rd_burst_req}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_rd_req", {31'd0, bus.rd_burst_req}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_queues("t4");

        // Full clean pass after the reset
        push_pass();
        pulse_start();
        wait_done("t5_done");
        check("t5_pass", {31'd0, pass}, 32'd1);
        check("t5_err_count", 32'(err_count), 32'd0);
        check("t5_timeout", {31'd0, timeout}, 32'd0);
        repeat (3) @(negedge clk);
        check_queues("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_traffic_gen.md
SDRAM_TRAFFIC_GEN -- requirements
Module: sdram_traffic_gen

Interface
REQ-001 Param SDR_DQ_WIDTH, 16, data word width.
REQ-002 Param APP_ADDR_WIDTH, 24, application address width ({bank,row,col}).
REQ-003 Param APP_BURST_WIDTH, 10, burst-length field width.
REQ-004 Param BURST_LEN, 8, words per burst (1..2^APP_BURST_WIDTH-1).
REQ-005 Param NUM_BURSTS, 16, bursts per pass (>=1).
REQ-006 Param START_ADDR, 0, first burst address.
REQ-007 Param PATTERN, 0, data mode: 0 incrementing, 1 LFSR, 2 walking-one.
REQ-008 Param TIMEOUT, 4096, max cycles from req assertion to finish.
REQ-009 One clock; reset is synchronous and active-high; ports: clk in 1, rst in 1.
REQ-010 start in 1, pulse begins one write-then-read pass; ignored unless IDLE or DONE.
REQ-011 wr_burst_req out 1; wr_burst_len out APP_BURST_WIDTH; wr_burst_addr out APP_ADDR_WIDTH; wr_burst_data out SDR_DQ_WIDTH.
REQ-012 wr_burst_data_req in 1, controller consumes wr_burst_data this cycle; wr_burst_finish in 1, write burst complete pulse.
REQ-013 rd_burst_req out 1; rd_burst_len out APP_BURST_WIDTH; rd_burst_addr out APP_ADDR_WIDTH.
REQ-014 rd_burst_data in SDR_DQ_WIDTH; rd_burst_data_valid in 1; rd_burst_finish in 1.
REQ-015 busy out 1; done out 1 (level); pass out 1; timeout out 1; err_count out 16; first_err_addr out APP_ADDR_WIDTH.

Function
REQ-016 FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE; busy=1 in all but IDLE/DONE.
REQ-017 IDLE/DONE + start -> WR_REQ; clears err_count, first_err_addr, timeout, done, pass; burst index b=0; pattern generator seeded.
REQ-018 WR_REQ: assert wr_burst_req, addr=START_ADDR+b*BURST_LEN (mod 2^APP_ADDR_WIDTH), len=BURST_LEN; next cycle WR_WAIT.
REQ-019 wr_burst_req held high through WR_WAIT until wr_burst_finish sampled high, then dropped next cycle.
REQ-020 wr_burst_data combinationally equals current pattern word; generator advances only on cycles with wr_burst_data_req=1.
REQ-021 On wr_burst_finish: b<NUM_BURSTS-1 -> b+1, WR_REQ; else b=0, reseed generator, RD_REQ.
REQ-022 RD_REQ/RD_WAIT mirror write: same addresses/len, rd_burst_req held until rd_burst_finish; after last burst -> DONE.
REQ-023 Each rd_burst_data_valid cycle: compare rd_burst_data to expected word, then advance generator; mismatch -> err_count+1 (saturate 16'hFFFF).
REQ-024 first_err_addr latches address of first mismatching word (burst addr + word offset); later mismatches do not overwrite.
REQ-025 Pattern, word index k from 0 per phase: mode 0 = k mod 2^SDR_DQ_WIDTH; mode 1 = Fibonacci LFSR, seed all-ones, taps maximal for 16 bit (x^16+x^14+x^13+x^11+1), replicated/truncated to width; mode 2 = 1<<(k mod SDR_DQ_WIDTH).
REQ-026 Valid beats beyond BURST_LEN in a burst still compared; fewer beats than BURST_LEN before finish count as no error (generator resynced to next burst start at each RD_REQ).
REQ-027 Watchdog counter resets on entry to WR_REQ/RD_REQ; reaching TIMEOUT in WR_WAIT/RD_WAIT -> drop req, timeout=1, DONE.
REQ-028 DONE: done=1, pass=(err_count==0)&&!timeout; outputs held until next start.
REQ-029 finish and data_req/valid in same cycle: data handled first, then transition.
REQ-030 wr_burst_req and rd_burst_req never high together.

Reset
REQ-031 rst (sync) -> IDLE; all reqs 0, len/addr/data 0, busy/done/pass/timeout 0, err_count 0, first_err_addr 0; mid-burst reset drops req next edge, no further handshake.

Verification
REQ-032 Ideal SDRAM model, PATTERN=0, NUM_BURSTS=4, BURST_LEN=8 -> 4 write then 4 read bursts at addr 0,8,16,24; done=1, pass=1, err_count=0.
REQ-033 Model corrupts word 3 of burst 2 (bit0 flipped) -> err_count=1, first_err_addr=19, pass=0.
REQ-034 PATTERN=2, SDR_DQ_WIDTH=16 -> write words 0x0001,0x0002,...,0x8000,0x0001 wrap verified on bus.
REQ-035 Controller never asserts wr_burst_finish, TIMEOUT=64 -> req drops after 64 cycles, timeout=1, pass=0, done=1.
REQ-036 rst asserted during RD_WAIT -> next cycle rd_burst_req=0, busy=0; new start runs full pass cleanly.
REQ-037 start pulsed while busy -> ignored, burst sequence unchanged.
